// File: rtl/simon_pkg.sv
// Shared constants, state type and word helpers for the SIMON 32/64 engine.
// Decrypt support is compiled in only when SIMON_DECRYPT_EN is defined.
package simon_pkg;

  localparam int WORD_W       = 16;
  localparam int ROUNDS       = 32;
  localparam int EXPAND_STEPS = 28;

  // bit i holds z0[i]; the sequence has period 31
  localparam logic [61:0] Z0 =
    62'b0110011100001101010010001011111_0110011100001101010010001011111;

  localparam logic [WORD_W-1:0] C = 16'hFFFC;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXPAND,
    ROUND,
    DONE
  } state_t;

  typedef logic [3:0][WORD_W-1:0] win_t;

  function automatic logic [WORD_W-1:0] ror1(
    input logic [WORD_W-1:0] v
  );
    return {v[0], v[15:1]};
  endfunction

  function automatic logic [WORD_W-1:0] ror3(
    input logic [WORD_W-1:0] v
  );
    return {v[2:0], v[15:3]};
  endfunction

  function automatic logic [WORD_W-1:0] simon_f(
    input logic [WORD_W-1:0] v
  );
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]})
         ^ {v[13:0], v[15:14]};
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// One SIMON 32/64 key-schedule step on a 4-word window k[i..i+3].
// back_i selects the inverse step (SIMON_DECRYPT_EN builds only).
module simon_key_step
  import simon_pkg::*;
(
  input  win_t win_i,
  input  logic z_i,
  input  logic back_i,
  output win_t win_o
);

  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;
  logic [WORD_W-1:0] old;
  logic [WORD_W-1:0] tmp0;
  logic [WORD_W-1:0] tmp;
  logic [WORD_W-1:0] nk;

`ifdef SIMON_DECRYPT_EN
  // backward window is k[i+1..i+4]; rebuild k[i] from the same taps
  assign hi  = back_i ? win_i[2] : win_i[3];
  assign lo  = back_i ? win_i[0] : win_i[1];
  assign old = back_i ? win_i[3] : win_i[0];
`else
  logic unused_back;
  assign unused_back = back_i;
  assign hi  = win_i[3];
  assign lo  = win_i[1];
  assign old = win_i[0];
`endif

  assign tmp0 = ror3(hi) ^ lo;
  assign tmp  = tmp0 ^ ror1(tmp0);
  assign nk   = C ^ old ^ tmp ^ {15'b0, z_i};

`ifdef SIMON_DECRYPT_EN
  assign win_o = back_i
    ? {win_i[2], win_i[1], win_i[0], nk}
    : {nk, win_i[3], win_i[2], win_i[1]};
`else
  assign win_o = {nk, win_i[3], win_i[2], win_i[1]};
`endif

endmodule

// File: rtl/simon32_core.sv
// Iterative SIMON 32/64: one round per clock, on-the-fly key schedule.
// Define SIMON_DECRYPT_EN to honour mode (decrypt via 28-step key expand).
module simon32_core
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] block,
  input  logic [63:0] key,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] x_q, x_d;
  logic [WORD_W-1:0] y_q, y_d;
  win_t              win_q, win_d;
  logic [31:0]       res_q, res_d;

  logic              dec;
  logic              ks_back;
  logic [4:0]        z_idx;
  logic [WORD_W-1:0] key_w;
  win_t              ks_win;

`ifdef SIMON_DECRYPT_EN
  logic dec_q, dec_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= 1'b0;
    else        dec_q <= dec_d;
  end

  always_comb begin
    dec_d = dec_q;
    if (start) dec_d = mode;
  end

  assign dec     = dec_q;
  assign ks_back = dec_q && (state_q == ROUND);
  // rounds j < 3 read k[j] straight from the final k[0..3] window
  assign key_w   = !dec_q ? win_q[0]
                 : (cnt_q < 5'd29) ? win_q[3]
                 : win_q[2'(5'd31 - cnt_q)];
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign dec         = 1'b0;
  assign ks_back     = 1'b0;
  assign key_w       = win_q[0];
`endif

  assign z_idx = ks_back ? (5'd27 - cnt_q) : cnt_q;

  simon_key_step u_key_step (
    .win_i  (win_q),
    .z_i    (Z0[z_idx]),
    .back_i (ks_back),
    .win_o  (ks_win)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    win_d   = win_q;
    res_d   = res_q;
    unique case (state_q)
`ifdef SIMON_DECRYPT_EN
      EXPAND: begin
        win_d = ks_win;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(EXPAND_STEPS - 1)) begin
          state_d = ROUND;
          cnt_d   = '0;
        end
      end
`endif
      ROUND: begin
        cnt_d = cnt_q + 5'd1;
        if (dec) begin
          x_d = y_q;
          y_d = x_q ^ simon_f(y_q) ^ key_w;
          if (cnt_q < 5'd28) win_d = ks_win;
        end else begin
          x_d   = y_q ^ simon_f(x_q) ^ key_w;
          y_d   = x_q;
          win_d = ks_win;
        end
        if (cnt_q == 5'(ROUNDS - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = {x_d, y_d};
        end
      end
      default: ;
    endcase
    // the start edge itself performs the load
    if (start) begin
      x_d   = block[31:16];
      y_d   = block[15:0];
      win_d = win_t'(key);
      cnt_d = '0;
`ifdef SIMON_DECRYPT_EN
      state_d = mode ? EXPAND : ROUND;
`else
      state_d = ROUND;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      res_q   <= res_d;
    end
  end

  assign result = res_q;
  assign busy   = (state_q == EXPAND) || (state_q == ROUND);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_simon32_core.sv
// Directed bench for simon32_core around the SIMON 32/64 known-answer pair.
// Expected decrypt behaviour follows SIMON_DECRYPT_EN.
module tb_simon32_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] block = '0;
  logic [63:0] key = '0;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_pass = 0;

  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [31:0] KAT_CT  = 32'hC69B_E9BB;
`ifdef SIMON_DECRYPT_EN
  localparam int          M1_LAT = 60;
  localparam logic [31:0] M1_IN  = KAT_CT;
  localparam logic [31:0] M1_OUT = KAT_PT;
`else
  localparam int          M1_LAT = 32;
  localparam logic [31:0] M1_IN  = KAT_PT;
  localparam logic [31:0] M1_OUT = KAT_CT;
`endif

  simon32_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .block  (block),
    .key    (key),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_start(
    input logic        m,
    input logic [31:0] b,
    input logic [63:0] k
  );
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    block = b;
    key   = k;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Observes lat edges after E0; collects busy/done and result-hold flags.
  task automatic run_cycles(
    input  int          lat,
    input  bit          scramble,
    input  logic [31:0] prev,
    output bit          flags_ok,
    output bit          held_ok
  );
    flags_ok = (busy === 1'b1) && (done === 1'b0);
    held_ok  = (result === prev);
    for (int n = 1; n <= lat; n++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        block = $urandom;
        key   = {$urandom, $urandom};
        mode  = 1'($urandom);
      end
      if (n < lat) begin
        if (busy !== 1'b1 || done !== 1'b0) flags_ok = 1'b0;
        if (result !== prev) held_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    n_chk++;
    if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_chk++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt_kat();
    bit fl, hd, hold_ok;
    do_start(1'b0, KAT_PT, KAT_KEY);
    run_cycles(32, 1'b0, 32'h0, fl, hd);
    n_chk++;
    if (!fl) $display("FAIL enc_busy_window: busy/done wrong before E32");
    else n_pass++;
    n_chk++;
    if (!hd) $display("FAIL enc_result_held: result moved before E32");
    else n_pass++;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL enc_done_e32: done=%b busy=%b want 1/0", done, busy);
    else n_pass++;
    n_chk++;
    if (result !== KAT_CT)
      $display("FAIL enc_kat: got %h want %h", result, KAT_CT);
    else n_pass++;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1 || busy !== 1'b0 || result !== KAT_CT)
        hold_ok = 1'b0;
    end
    n_chk++;
    if (!hold_ok) $display("FAIL done_sticky: got %h/%b want %h/1",
                           result, done, KAT_CT);
    else n_pass++;
  endtask

  task automatic test_restart();
    bit fl, hd, pre_ok;
    do_start(1'b0, 32'h0BAD_F00D, 64'h0123_4567_89AB_CDEF);
    pre_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b1 || result !== KAT_CT)
        pre_ok = 1'b0;
    end
    n_chk++;
    if (!pre_ok) $display("FAIL restart_first_op: done=%b busy=%b res=%h",
                          done, busy, result);
    else n_pass++;
    do_start(1'b1, M1_IN, KAT_KEY);
    run_cycles(M1_LAT, 1'b0, KAT_CT, fl, hd);
    n_chk++;
    if (!fl) $display("FAIL restart_busy_window: done rose early");
    else n_pass++;
    n_chk++;
    if (!hd) $display("FAIL restart_held: partial result exposed");
    else n_pass++;
    n_chk++;
    if (done !== 1'b1 || result !== M1_OUT)
      $display("FAIL restart_result: got %h done=%b want %h",
               result, done, M1_OUT);
    else n_pass++;
  endtask

  task automatic test_input_stability();
    bit fl, hd;
    do_start(1'b0, KAT_PT, KAT_KEY);
    run_cycles(32, 1'b1, M1_OUT, fl, hd);
    n_chk++;
    if (!fl || !hd) $display("FAIL stab_flags: flags=%b held=%b want 1/1",
                             fl, hd);
    else n_pass++;
    n_chk++;
    if (done !== 1'b1 || result !== KAT_CT)
      $display("FAIL stab_result: got %h want %h", result, KAT_CT);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit fl, hd;
    do_start(1'b0, 32'h1357_9BDF, KAT_KEY);
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (result !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL async_reset: res=%h busy=%b done=%b want 0/0/0",
               result, busy, done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    do_start(1'b0, KAT_PT, KAT_KEY);
    run_cycles(32, 1'b0, 32'h0, fl, hd);
    n_chk++;
    if (!fl || !hd || done !== 1'b1 || result !== KAT_CT)
      $display("FAIL post_reset_kat: got %h done=%b want %h",
               result, done, KAT_CT);
    else n_pass++;
  endtask

  task automatic test_mode1();
    bit fl, hd;
    do_start(1'b1, M1_IN, KAT_KEY);
    run_cycles(M1_LAT, 1'b0, KAT_CT, fl, hd);
    n_chk++;
    if (!fl) $display("FAIL mode1_busy_window: busy/done wrong before end");
    else n_pass++;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== M1_OUT)
      $display("FAIL mode1_kat: got %h done=%b want %h",
               result, done, M1_OUT);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit fl, hd;
    logic [31:0] prev;
    prev = M1_OUT;
    for (int i = 0; i < 3; i++) begin
      do_start(1'b0, KAT_PT, KAT_KEY);
      n_chk++;
      if (done !== 1'b0)
        $display("FAIL b2b_done_clear: got %b want 0", done);
      else n_pass++;
      run_cycles(32, 1'b0, prev, fl, hd);
      n_chk++;
      if (!fl || !hd || result !== KAT_CT)
        $display("FAIL b2b_kat: got %h want %h", result, KAT_CT);
      else n_pass++;
      prev = KAT_CT;
    end
  endtask

`ifdef SIMON_DECRYPT_EN
  task automatic test_roundtrip();
    bit fl, hd;
    logic [31:0] pt, ct;
    logic [63:0] k;
    for (int i = 0; i < 100; i++) begin
      pt = $urandom;
      k  = {$urandom, $urandom};
      do_start(1'b0, pt, k);
      run_cycles(32, 1'b0, result, fl, hd);
      ct = result;
      do_start(1'b1, ct, k);
      run_cycles(60, 1'b0, ct, fl, hd);
      n_chk++;
      if (!fl || done !== 1'b1 || result !== pt)
        $display("FAIL roundtrip_%0d: got %h want %h", i, result, pt);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt_kat();
    test_restart();
    test_input_stability();
    test_async_reset();
    test_mode1();
    test_back_to_back();
`ifdef SIMON_DECRYPT_EN
    test_roundtrip();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/simon32_core.md
# simon32_core

Iterative SIMON 32/64 cipher engine that sits directly downstream of the SPI command/control FSM. It consumes the latched 32-bit block, 64-bit key and mode together with a one-cycle start pulse. It computes one Feistel round per clock with an on-the-fly key schedule, then holds the 32-bit result with a sticky done flag until the next start.

## Interface
- No parameters. Cipher geometry is fixed: word 16, m 4, T 32, sequence z0.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; samples block/key/mode and (re)starts the operation.
- mode  in  1  0 = encrypt, 1 = decrypt.
- block  in  32  input block: [31:16] = x (left word), [15:0] = y (right word).
- key  in  64  key words: [15:0] = k0, [31:16] = k1, [47:32] = k2, [63:48] = k3.
- result  out  32  output block, same x/y layout as block; valid while done = 1.
- busy  out  1  operation in progress.
- done  out  1  sticky completion flag; cleared by start or reset.

## Operation
- Notation:
  - S^n = 16-bit rotate left by n.
  - f(x) = (S^1 x & S^8 x) ^ S^2 x.
- Key schedule (forward):
  - tmp = S^-3 k[i+3] ^ k[i+1].
  - tmp ^= S^-1 tmp.
  - k[i+4] = ~k[i] ^ tmp ^ z0[i] ^ 16'h0003.
  - A 4-word window holds k[i..i+3].
- Inverse key step: k[i] = ~(k[i+4] ^ tmp ^ z0[i] ^ 16'h0003), with tmp computed from k[i+3] and k[i+1]. The window shifts the other way.
- Encrypt round i (0..31):
  - x' = y ^ f(x) ^ k[i]; y' = x.
  - Then the window advances forward using z0[i].
- Decrypt round j (31..0):
  - x' = y; y' = x ^ f(y) ^ k[j].
  - Then the window steps back using z0[j-4]; this step is skipped for j < 4.
- FSM states and transitions:
  - IDLE → LOAD on start.
  - LOAD: load x/y/window, set cnt = 0. Go to EXPAND if mode = 1, otherwise go to ROUND.
  - EXPAND: 28 forward key steps (cnt 0..27). At exit the window holds k[28..31].
  - ROUND: 32 rounds, cnt 0..31. Go to DONE after cnt = 31.
  - DONE: result holds the final state and done = 1. A new start returns to LOAD.
- A start in any state, including mid-EXPAND or mid-ROUND, aborts the current operation and re-samples inputs. done is cleared on that same edge.
- The block, key and mode inputs are ignored except on the start edge. Upstream may change them freely while busy.
- All arithmetic is on 16-bit words. The 5-bit cnt wraps only under FSM control, never freely.

## Timing
- Reset values: result = 0, busy = 0, done = 0, FSM = IDLE, window/x/y = 0.
- Call the start-sampling edge E0.
  - busy = 1 from E0 until the final round edge.
- Encrypt:
  - Rounds occupy edges E1..E32.
  - done = 1 and busy = 0 after E32. Latency is 32 cycles.
- Decrypt:
  - Expansion occupies E1..E28 and rounds occupy E29..E60.
  - done = 1 after E60. Latency is 60 cycles.
- result changes only on the final round edge and on reset. It is stable throughout DONE.
- done and busy are never 1 simultaneously.
- Downstream capture condition: done && !start.
- Reset asserted mid-operation returns to reset values immediately (asynchronous); no partial result is kept.

## Configuration
- SIMON_DECRYPT_EN defined:
  - mode is honoured.
  - EXPAND state, inverse key step and decrypt datapath are compiled in.
- SIMON_DECRYPT_EN undefined:
  - mode is ignored and every start encrypts (32-cycle latency).
  - EXPAND and inverse logic are absent.
  - The mode port remains present but is unused.

## Structure
- Shared package simon_pkg contains:
  - Constants: WORD_W = 16, ROUNDS = 32, EXPAND_STEPS = 28.
  - Z0 as a 62-bit constant with bit i = z0[i] (standard SIMON z0 sequence).
  - Key constant C = 16'hFFFC.
  - FSM state typedef: IDLE, LOAD, EXPAND, ROUND, DONE.
- One sub-module: simon_key_step. It is combinational, taking the 4-word window, z bit and direction, and returning the next window.
- Round function, counter and FSM live in simon32_core.

## Test plan
- Encrypt KAT: key = 64'h1918_1110_0908_0100, block = 32'h6565_6877, mode 0, start → after exactly 32 cycles done = 1, result = 32'hC69B_E9BB.
- Decrypt KAT: same key, block = 32'hC69B_E9BB, mode 1 → after exactly 60 cycles done = 1, result = 32'h6565_6877.
- Restart mid-operation: start encrypt, pulse start again (decrypt) at cycle 10 → done stays 0 throughout; result is the correct decrypt value 60 cycles after the second start.
- Input stability: change block/key/mode every cycle while busy → result equals the KAT value for the inputs sampled at start.
- Async reset at round 15 → result/busy/done = 0 immediately. A subsequent start yields the encrypt KAT normally.
- Round-trip: 100 random key/block pairs, encrypt then decrypt → original block recovered. With SIMON_DECRYPT_EN undefined, mode 1 produces the encrypt result in 32 cycles.
